dtree_seq_eval: RTL and testbench

- Sequential, table-driven decision-tree classifier controller for the pendigits flow.
- Time-multiplexes one 8-bit "feature <= threshold" comparator across all internal nodes of a tree held in a writable node table. It walks one node per clock from the root to a leaf.
- Replaces fully unrolled combinational trees when area matters more than latency.
- Sits between the feature-sample source (valid/ready) and the class consumer (valid/ready). A host loads the tree through a config write port.

---
 rtl/dtree_seq_eval.sv | 142 ++++++++++++++
 tb/tb_dtree_seq_eval.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dtree_seq_eval.sv
// dtree_seq_eval: sequential table-driven decision-tree classifier.
// One 8-bit "feature <= threshold" comparator is time-multiplexed across the
// internal nodes of a tree held in a writable node table, walking one node
// per clock from the root (entry 0) to a leaf.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   sample handshake; in_feat holds NUM_FEAT features,
//                       feature i at in_feat[i*FEAT_W +: FEAT_W]
//   out_valid/out_ready result handshake; out_class, out_err (step-limit
//                       abort), out_depth (internal nodes visited)
//   cfg_we/cfg_addr/cfg_wdata  node-table write port, honoured only while
//                       cfg_ready (IDLE). Entry layout:
//                       {leaf, feat[3:0], thr[FEAT_W-1:0], left[AW-1:0], right[AW-1:0]}
module dtree_seq_eval #(
  parameter int NUM_FEAT  = 16,
  parameter int FEAT_W    = 8,
  parameter int NODES     = 32,
  parameter int CLS_W     = 4,
  parameter int MAX_STEPS = 15,
  localparam int AW       = $clog2(NODES),
  localparam int EW       = 1 + 4 + FEAT_W + 2 * AW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_FEAT*FEAT_W-1:0] in_feat,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CLS_W-1:0]           out_class,
  output logic                       out_err,
  output logic [3:0]                 out_depth,
  input  logic                       cfg_we,
  input  logic [AW-1:0]              cfg_addr,
  input  logic [EW-1:0]              cfg_wdata,
  output logic                       cfg_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                     state, state_nx;
  logic [EW-1:0]              node_mem [NODES];
  logic [NUM_FEAT*FEAT_W-1:0] feat_q;
  logic [AW-1:0]              cur;
  logic [3:0]                 steps;

  // Current node decode
  logic [EW-1:0]     node;
  logic              node_leaf;
  logic [3:0]        node_feat;
  logic [FEAT_W-1:0] node_thr;
  logic [AW-1:0]     node_left;
  logic [AW-1:0]     node_right;
  logic [FEAT_W-1:0] feat_sel;
  logic              go_left;
  logic              at_limit;

  assign node       = node_mem[cur];
  assign node_leaf  = node[EW-1];
  assign node_feat  = node[EW-2 -: 4];
  assign node_thr   = node[2*AW +: FEAT_W];
  assign node_left  = node[AW +: AW];
  assign node_right = node[0 +: AW];

  // Feature indices beyond NUM_FEAT read as zero.
  always_comb begin
    feat_sel = '0;
    if (int'(node_feat) < NUM_FEAT)
      feat_sel = feat_q[node_feat*FEAT_W +: FEAT_W];
  end

  // Unsigned full-width compare; bit-sliced splits are pre-encoded in thr.
  assign go_left  = (feat_sel <= node_thr);
  assign at_limit = (steps == 4'(MAX_STEPS));

  assign in_ready  = (state == IDLE);
  assign cfg_ready = (state == IDLE);
  assign out_valid = (state == DONE);

  // Node table: not reset, written only while idle.
  always_ff @(posedge clk) begin
    if (cfg_we && cfg_ready)
      node_mem[cfg_addr] <= cfg_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = WALK;
      WALK:    if (node_leaf || at_limit) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      feat_q    <= '0;
      cur       <= '0;
      steps     <= '0;
      out_class <= '0;
      out_err   <= 1'b0;
      out_depth <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            feat_q <= in_feat;
            cur    <= '0;
            steps  <= '0;
          end
        end
        WALK: begin
          if (node_leaf) begin
            out_class <= node[CLS_W-1:0];
            out_err   <= 1'b0;
            out_depth <= steps;
          end else if (at_limit) begin
            out_class <= '1;
            out_err   <= 1'b1;
            out_depth <= steps;
          end else begin
            cur   <= go_left ? node_left : node_right;
            steps <= steps + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dtree_seq_eval.sv
// tb_dtree_seq_eval: scoreboard bench for dtree_seq_eval. The driver pushes
// hand-computed expected results; a negedge monitor checks latency on the
// rising edge of out_valid and pops/compares on each accepted result.
module tb_dtree_seq_eval;
  localparam int AW = 5;
  localparam int EW = 23;

  logic          clk, rst;
  logic          in_valid, in_ready;
  logic [127:0]  in_feat;
  logic          out_valid, out_ready, out_err;
  logic [3:0]    out_class, out_depth;
  logic          cfg_we, cfg_ready;
  logic [AW-1:0] cfg_addr;
  logic [EW-1:0] cfg_wdata;

  typedef struct {
    logic [3:0] cls;
    logic       err;
    logic [3:0] depth;
    int         lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  logic prev_v = 1'b0;

  dtree_seq_eval #(
    .NUM_FEAT(16), .FEAT_W(8), .NODES(32), .CLS_W(4), .MAX_STEPS(15)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_feat(in_feat),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
    .out_err(out_err), .out_depth(out_depth),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_ready(cfg_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic logic [EW-1:0] mk_node(input logic [3:0] f, input logic [7:0] t,
                                            input logic [AW-1:0] l, input logic [AW-1:0] r);
    return {1'b0, f, t, l, r};
  endfunction

  function automatic logic [EW-1:0] mk_leaf(input logic [3:0] c);
    return {1'b1, 18'd0, c};
  endfunction

  function automatic logic [127:0] mk_feat(input int idx, input logic [7:0] v, input logic [7:0] fill);
    logic [127:0] f;
    for (int i = 0; i < 16; i++) f[i*8 +: 8] = (i == idx) ? v : fill;
    return f;
  endfunction

  function automatic exp_t mk_exp(input logic [3:0] c, input logic e, input logic [3:0] d);
    exp_t x;
    x.cls = c; x.err = e; x.depth = d; x.lat = int'(d) + 1;
    return x;
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid && !prev_v) begin
        if (sb.size() == 0) check("unexpected_out_valid", 1, 0);
        else check("latency", cyc - acc_cyc, sb[0].lat);
      end
      if (out_valid && out_ready && sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("out_class", int'(out_class), int'(mon_e.cls));
        check("out_err",   int'(out_err),   int'(mon_e.err));
        check("out_depth", int'(out_depth), int'(mon_e.depth));
      end
      prev_v = out_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 200) begin tick(); n++; end
    if (!in_ready) check("idle_timeout", 0, 1);
  endtask

  task automatic cfg_write(input logic [AW-1:0] a, input logic [EW-1:0] d);
    wait_idle();
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic send(input logic [127:0] f, input exp_t e, input bit push);
    wait_idle();
    if (push) sb.push_back(e);
    in_valid = 1'b1; in_feat = f;
    tick();
    acc_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 200) begin tick(); n++; end
    if (sb.size() != 0) check("result_timeout", sb.size(), 0);
  endtask

  task automatic x15(input logic [7:0] v, input logic [3:0] c, input logic [3:0] d);
    send(mk_feat(15, v, 8'hA5), mk_exp(c, 1'b0, d), 1'b1);
    wait_done();
  endtask

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; in_feat = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_class", int'(out_class), 0);
    check("rst_out_err",   int'(out_err),   0);
    check("rst_out_depth", int'(out_depth), 0);
    check("rst_in_ready",  int'(in_ready),  1);
    check("rst_cfg_ready", int'(cfg_ready), 1);

    // Root leaf
    cfg_write(0, mk_leaf(4'd7));
    x15(8'd0, 4'd7, 4'd0);

    // Three-node tree on feature 15
    cfg_write(0, mk_node(4'd15, 8'd63, 5'd1, 5'd2));
    cfg_write(1, mk_leaf(4'd3));
    cfg_write(2, mk_leaf(4'd9));
    x15(8'd63, 4'd3, 4'd1);
    x15(8'd64, 4'd9, 4'd1);
    x15(8'd0,  4'd3, 4'd1);

    // Feature selection on a non-top feature
    cfg_write(0, mk_node(4'd3, 8'd100, 5'd1, 5'd2));
    cfg_write(1, mk_leaf(4'd1));
    cfg_write(2, mk_leaf(4'd2));
    send(mk_feat(3, 8'd100, 8'hFF), mk_exp(4'd1, 1'b0, 4'd1), 1'b1); wait_done();
    send(mk_feat(3, 8'd101, 8'h00), mk_exp(4'd2, 1'b0, 4'd1), 1'b1); wait_done();

    // Bit-sliced depth-4 tree on feature 15
    cfg_write(0,  mk_node(4'd15, 8'd63,  5'd1, 5'd5));   // X[7:6] <= 0
    cfg_write(1,  mk_node(4'd15, 8'd31,  5'd6, 5'd7));   // X[7:5] <= 0
    cfg_write(5,  mk_node(4'd15, 8'd127, 5'd8, 5'd9));   // X[7:2] <= 31
    cfg_write(9,  mk_node(4'd15, 8'd191, 5'd10, 5'd11)); // X[7:4] <= 11
    cfg_write(11, mk_node(4'd15, 8'd247, 5'd12, 5'd13)); // X[7:3] <= 30
    cfg_write(6,  mk_leaf(4'd2));
    cfg_write(7,  mk_leaf(4'd3));
    cfg_write(8,  mk_leaf(4'd4));
    cfg_write(10, mk_leaf(4'd5));
    cfg_write(12, mk_leaf(4'd6));
    cfg_write(13, mk_leaf(4'd7));
    x15(8'd0,   4'd2, 4'd2);
    x15(8'd40,  4'd3, 4'd2);
    x15(8'd64,  4'd4, 4'd2);
    x15(8'd127, 4'd4, 4'd2);
    x15(8'd128, 4'd5, 4'd3);
    x15(8'd200, 4'd6, 4'd4);
    x15(8'd255, 4'd7, 4'd4);

    // Reset in the middle of a walk
    send(mk_feat(15, 8'd255, 8'h00), mk_exp(4'd7, 1'b0, 4'd4), 1'b0);
    tick(); tick();
    rst = 1'b1;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_in_ready",  int'(in_ready),  1);
    check("midrst_cfg_ready", int'(cfg_ready), 1);
    tick();
    rst = 1'b0;
    x15(8'd200, 4'd6, 4'd4);

    // Backpressure, with a write attempted while busy
    cfg_write(0, mk_node(4'd15, 8'd63, 5'd1, 5'd2));
    cfg_write(1, mk_leaf(4'd3));
    cfg_write(2, mk_leaf(4'd9));
    out_ready = 1'b0;
    send(mk_feat(15, 8'd64, 8'h11), mk_exp(4'd9, 1'b0, 4'd1), 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    check("bp_valid_seen", int'(out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_out_class", int'(out_class), 9);
      check("bp_in_ready",  int'(in_ready),  0);
      cfg_we = (i == 1); cfg_addr = 5'd2; cfg_wdata = mk_leaf(4'd12);
      tick();
    end
    cfg_we = 1'b0;
    out_ready = 1'b1;
    wait_done();
    x15(8'd64, 4'd9, 4'd1);

    // Self-loop hits the step limit
    cfg_write(0, mk_node(4'd0, 8'd0, 5'd0, 5'd0));
    send(mk_feat(15, 8'd0, 8'h00), mk_exp(4'hF, 1'b1, 4'd15), 1'b1);
    wait_done();

    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
